// File: rtl/cpu16_pkg.sv
// Shared opcode, ALU-class and FSM encodings for the 16-bit CPU front end,
// plus the control bundle passed from the decoder to the sequencer.
package cpu16_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_ILL   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_COMMIT,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       mul_reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Settling view of a control bundle: everything except the state-changing strobes.
  function automatic ctrl_t strip_writes(input ctrl_t c);
    ctrl_t r;
    r               = c;
    r.mem_write     = 1'b0;
    r.reg_write     = 1'b0;
    r.mul_reg_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode decoder: maps Instruction[15:13] to the full control
// bundle, flagging the halt opcode and the single undefined opcode.
module main_decoder
  import cpu16_pkg::*;
#(
  parameter logic [2:0] HALT_OPCODE = OP_HALT
) (
  input  logic [2:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       halt
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned, which would infer a latch.
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    halt    = 1'b0;
    if (opcode == HALT_OPCODE) begin
      halt = 1'b1;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        OP_ADDI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_LW: begin
          ctrl.alu_src    = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.alu_op     = ALUOP_ADD;
        end
        OP_SW: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_BEQ: begin
          ctrl.branch = 1'b1;
          ctrl.alu_op = ALUOP_SUB;
        end
        OP_MUL: begin
          ctrl.reg_dst       = 1'b1;
          ctrl.mul_reg_write = 1'b1;
          ctrl.alu_op        = ALUOP_FUNCT;
        end
        // Undefined opcode executes as a NOP with no controls.
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fetch_control_unit.sv
// Multi-cycle fetch/execute sequencer for the 16-bit CPU (FETCH, EXEC, COMMIT, HALT).
// Define FETCH_CONTROL_RETIRE_COUNT_EN to build the saturating retired-instruction counter.
module fetch_control_unit
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [2:0]  HALT_OPCODE = OP_HALT
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] IAddr,
  output logic        IReq,
  input  logic        IAck,
  input  logic [15:0] IData,
  output logic [15:0] Instruction,
  output logic [15:0] PCNext,
  input  logic [15:0] BEQPC,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MulRegWrite,
  output logic [1:0]  ALUOp,
  output logic        Halted,
  output logic        IllegalOp,
  output logic [15:0] InstrRetired
);

  localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

  state_t      state, state_next;
  logic [15:0] pc;
  logic [15:0] instr_q;
  logic        illegal_q;
  logic [2:0]  dec_opcode;
  ctrl_t       dec_ctrl;
  ctrl_t       ctrl_out;
  logic        dec_illegal;
  logic        dec_halt;
  logic        fetch_done;
  logic        beqpc_lsb_unused;

  assign beqpc_lsb_unused = BEQPC[0];
  assign fetch_done       = (state == S_FETCH) && IAck;

  // During FETCH the decoder looks at the incoming word so IllegalOp rises with the fetch itself.
  assign dec_opcode = (state == S_FETCH) ? IData[15:13] : instr_q[15:13];

  main_decoder #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_decoder (
    .opcode  (dec_opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .halt    (dec_halt)
  );

  always_comb begin
    state_next = state;
    ctrl_out   = CTRL_NONE;
    case (state)
      S_FETCH: begin
        if (IAck) state_next = S_EXEC;
      end
      S_EXEC: begin
        ctrl_out   = strip_writes(dec_ctrl);
        state_next = dec_halt ? S_HALT : S_COMMIT;
      end
      S_COMMIT: begin
        ctrl_out   = dec_ctrl;
        state_next = S_FETCH;
      end
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (Reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC_ALIGNED;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (fetch_done) begin
        instr_q <= IData;
        if (dec_illegal) illegal_q <= 1'b1;
      end
      if (state == S_COMMIT) pc <= {BEQPC[15:1], 1'b0};
    end
  end

`ifdef FETCH_CONTROL_RETIRE_COUNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      retired_q <= '0;
    end else if ((state == S_COMMIT) && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign InstrRetired = retired_q;
`else
  assign InstrRetired = 16'h0000;
`endif

  // Request is masked while Reset is held so a reset cycle never looks like a live fetch.
  assign IReq        = (state == S_FETCH) && !Reset;
  assign IAddr       = pc;
  assign PCNext      = pc + 16'd2;
  assign Instruction = instr_q;
  assign Halted      = (state == S_HALT);
  assign IllegalOp   = illegal_q;

  assign RegDst      = ctrl_out.reg_dst;
  assign Branch      = ctrl_out.branch;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign MemToReg    = ctrl_out.mem_to_reg;
  assign ALUSrc      = ctrl_out.alu_src;
  assign RegWrite    = ctrl_out.reg_write;
  assign MulRegWrite = ctrl_out.mul_reg_write;
  assign ALUOp       = ctrl_out.alu_op;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Scoreboard bench for fetch_control_unit: the driver pushes the expected behaviour of each
// instruction it hands over, and a negedge monitor follows the handshake and compares.
module tb_fetch_control_unit;

  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [9:0]  WRITE_MASK = 10'b0001001100;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IAddr;
  logic        IReq;
  logic        IAck;
  logic [15:0] IData;
  logic [15:0] Instruction;
  logic [15:0] PCNext;
  logic [15:0] BEQPC;
  logic        RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, MulRegWrite;
  logic [1:0]  ALUOp;
  logic        Halted;
  logic        IllegalOp;
  logic [15:0] InstrRetired;
  logic [9:0]  ctrl_obs;

  fetch_control_unit #(
    .RESET_PC    (RESET_PC),
    .HALT_OPCODE (3'b111)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .IAddr        (IAddr),
    .IReq         (IReq),
    .IAck         (IAck),
    .IData        (IData),
    .Instruction  (Instruction),
    .PCNext       (PCNext),
    .BEQPC        (BEQPC),
    .RegDst       (RegDst),
    .Branch       (Branch),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemToReg     (MemToReg),
    .ALUSrc       (ALUSrc),
    .RegWrite     (RegWrite),
    .MulRegWrite  (MulRegWrite),
    .ALUOp        (ALUOp),
    .Halted       (Halted),
    .IllegalOp    (IllegalOp),
    .InstrRetired (InstrRetired)
  );

  always #5 Clock = ~Clock;

  assign ctrl_obs = {RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, MulRegWrite, ALUOp};

  // Control table indexed by opcode, bits {RegDst,Branch,MemRead,MemWrite,MemToReg,ALUSrc,RegWrite,MulRegWrite,ALUOp}.
  logic [9:0] ctrl_tbl [8] = '{
    10'b1000001010,  // R-type
    10'b0000011000,  // ADDI
    10'b0010111000,  // LW
    10'b0001010000,  // SW
    10'b0100000001,  // BEQ
    10'b1000000110,  // MUL
    10'b0000000000,  // illegal
    10'b0000000000   // HALT
  };

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] next_pc;
    logic [9:0]  ctrl;
    bit          halt;
    bit          ill_after;
    logic [15:0] ret_before;
    logic [15:0] ret_after;
  } item_t;

  item_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          commits_exp = 0;
  int          commits_seen = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_pc;
  bit          m_ill;
  logic [15:0] m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ret_inc(input logic [15:0] r);
`ifdef FETCH_CONTROL_RETIRE_COUNT_EN
    return (r == 16'hFFFF) ? r : r + 16'd1;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Two reset cycles; outputs are checked after the first edge while Reset is still high.
  task automatic do_reset(input bit ack_during);
    check("pending_items", exp_q.size(), 0);
    mon_en = 1'b0;
    Reset  = 1'b1;
    IAck   = ack_during;
    IData  = 16'hC000;
    tick();
    check("rst_ireq", IReq, 0);
    check("rst_iaddr", IAddr, RESET_PC);
    check("rst_instr", Instruction, 0);
    check("rst_ctrl", ctrl_obs, 0);
    check("rst_halted", Halted, 0);
    check("rst_illegal", IllegalOp, 0);
    check("rst_retired", InstrRetired, 0);
    IAck = 1'b0;
    tick();
    exp_q.delete();
    m_pc   = {RESET_PC[15:1], 1'b0};
    m_ill  = 1'b0;
    m_ret  = '0;
    Reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Hand one instruction over after `waits` idle FETCH cycles; spurious acks are thrown in afterwards.
  task automatic issue(input logic [15:0] instr, input logic [15:0] beqpc, input int waits);
    item_t      it;
    logic [2:0] op;
    op = instr[15:13];
    repeat (waits) begin
      IAck  = 1'b0;
      IData = 16'($urandom);
      tick();
    end
    it.pc         = m_pc;
    it.instr      = instr;
    it.ctrl       = ctrl_tbl[op];
    it.halt       = (op == 3'b111);
    it.ill_after  = m_ill | (op == 3'b110);
    it.ret_before = m_ret;
    it.next_pc    = it.halt ? m_pc : {beqpc[15:1], 1'b0};
    it.ret_after  = it.halt ? m_ret : ret_inc(m_ret);
    exp_q.push_back(it);
    m_pc  = it.next_pc;
    m_ill = it.ill_after;
    m_ret = it.ret_after;
    if (!it.halt) commits_exp++;
    IAck  = 1'b1;
    IData = instr;
    BEQPC = beqpc;
    tick();
    IAck  = 1'($urandom_range(0, 1));
    IData = 16'($urandom);
    tick();
    if (!it.halt) begin
      IAck = 1'($urandom_range(0, 1));
      tick();
    end
    IAck = 1'b0;
  endtask

  typedef enum {M_IDLE, M_EXEC, M_COMMIT, M_HALT} mphase_t;
  mphase_t     ph;
  item_t       cur;
  logic [15:0] fpc;
  bit          fill;
  logic [15:0] fret;

  initial begin
    ph = M_IDLE;
    forever begin
      @(negedge Clock);
      if (!mon_en) begin
        ph   = M_IDLE;
        fpc  = {RESET_PC[15:1], 1'b0};
        fill = 1'b0;
        fret = '0;
      end else begin
        case (ph)
          M_IDLE: begin
            check("fetch_ireq", IReq, 1);
            check("fetch_iaddr", IAddr, fpc);
            check("fetch_pcnext", PCNext, 16'(fpc + 16'd2));
            check("fetch_ctrl", ctrl_obs, 0);
            check("fetch_halted", Halted, 0);
            check("fetch_illegal", IllegalOp, 32'(fill));
            check("fetch_retired", InstrRetired, fret);
            if (IAck) begin
              if (exp_q.size() == 0) begin
                check("ack_items", exp_q.size(), 1);
              end else begin
                cur = exp_q.pop_front();
                ph  = M_EXEC;
              end
            end
          end
          M_EXEC: begin
            check("exec_ireq", IReq, 0);
            check("exec_pc", IAddr, cur.pc);
            check("exec_instr", Instruction, cur.instr);
            check("exec_ctrl", ctrl_obs, cur.ctrl & ~WRITE_MASK);
            check("exec_halted", Halted, 0);
            check("exec_illegal", IllegalOp, 32'(cur.ill_after));
            check("exec_retired", InstrRetired, cur.ret_before);
            if (cur.halt) begin
              fill = cur.ill_after;
              fret = cur.ret_before;
              ph   = M_HALT;
            end else begin
              ph = M_COMMIT;
            end
          end
          M_COMMIT: begin
            check("commit_ireq", IReq, 0);
            check("commit_pc", IAddr, cur.pc);
            check("commit_instr", Instruction, cur.instr);
            check("commit_ctrl", ctrl_obs, cur.ctrl);
            check("commit_halted", Halted, 0);
            check("commit_illegal", IllegalOp, 32'(cur.ill_after));
            check("commit_retired", InstrRetired, cur.ret_before);
            commits_seen++;
            fpc  = cur.next_pc;
            fill = cur.ill_after;
            fret = cur.ret_after;
            ph   = M_IDLE;
          end
          default: begin
            check("halt_halted", Halted, 1);
            check("halt_ireq", IReq, 0);
            check("halt_pc", IAddr, cur.pc);
            check("halt_ctrl", ctrl_obs, 0);
            check("halt_illegal", IllegalOp, 32'(fill));
            check("halt_retired", InstrRetired, fret);
          end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [15:0] beq;
    Reset = 1'b1;
    IAck  = 1'b0;
    IData = '0;
    BEQPC = '0;
    do_reset(1'b0);

    issue(16'h2081, 16'h0002, 0);  // ADDI, zero-wait ack
    issue(16'h0123, 16'h0004, 4);  // R-type, ack delayed 4 cycles
    issue(16'h8000, 16'h0010, 1);  // BEQ taken
    issue(16'h8123, 16'h0011, 0);  // odd BEQPC, bit 0 dropped
    issue(16'h6000, 16'hFFFE, 0);  // SW, next PC at the top of memory
    issue(16'h4000, 16'h0021, 2);  // LW at FFFE: PCNext wraps to 0000
    issue(16'hA000, 16'h0022, 0);  // MUL
    issue(16'hC000, 16'h0024, 1);  // illegal: NOP, sticky flag
    issue(16'h2000, 16'h0026, 0);
    issue(16'hE000, 16'h1234, 0);  // HALT
    repeat (5) begin
      IAck = 1'($urandom_range(0, 1));
      tick();
    end
    IAck = 1'b0;
    do_reset(1'b0);

    for (int i = 0; i < 200; i++) begin
      op  = 3'($urandom_range(0, 6));
      beq = ($urandom_range(0, 9) == 0) ? (16'hFFFE | 16'($urandom_range(0, 1))) : 16'($urandom);
      issue({op, 13'($urandom)}, beq, int'($urandom_range(0, 3)));
    end

    // Reset lands mid-FETCH with an acknowledge on the same edge.
    repeat (2) begin
      IAck = 1'b0;
      tick();
    end
    do_reset(1'b1);
    issue(16'h0000, 16'h0040, 0);
    issue(16'hE000, 16'h0000, 0);
    repeat (3) tick();

    check("pending_items", exp_q.size(), 0);
    check("commits_seen", commits_seen, commits_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
